// File: rtl/lobster_dbus_arbiter_pkg.sv
// Shared types for the lobster128 data-bus arbiter: owner and FSM state
// encodings plus the default bus widths.
package lobster_pkg;

  localparam int unsigned DBUS_ADDR_WIDTH = 36;
  localparam int unsigned DBUS_DATA_WIDTH = 64;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LSU   = 1'b1
  } dbus_owner_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dbus_state_t;

  // The requester that is not o; used to hand round-robin priority over.
  function automatic dbus_owner_t dbus_other(input dbus_owner_t o);
    return (o == OWN_LSU) ? OWN_FETCH : OWN_LSU;
  endfunction

endpackage

// File: rtl/lobster_dbus_arbiter_if.sv
// Requester and SRAM-side signals of the data-bus arbiter. The master modport
// is the arbiter itself; slave is the pipeline/SRAM environment.
interface lobster_dbus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = lobster_pkg::DBUS_ADDR_WIDTH
);
  localparam int unsigned DW = lobster_pkg::DBUS_DATA_WIDTH;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic                  if_err;
  logic [DW-1:0]         if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DW-1:0]         ls_wdata;
  logic                  ls_done;
  logic                  ls_err;
  logic [DW-1:0]         ls_rdata;

  logic                  mem_ce;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_rdata;
  logic                  mem_rdy;

  logic                  busy;
  logic                  owner;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_rdy,
    output if_done, if_err, if_rdata, ls_done, ls_err, ls_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_rdy,
    input  if_done, if_err, if_rdata, ls_done, ls_err, ls_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata, busy, owner
  );

endinterface

// File: rtl/lobster_dbus_arbiter_wdog.sv
// rdy watchdog: counts ACCESS cycles; expired is high on the cycle where the
// count reaches TIMEOUT_CYCLES-1 (registered one cycle ahead).
module lobster_dbus_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PRE_LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (run) begin
      cnt     <= cnt + CW'(1);
      expired <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/lobster_dbus_arbiter.sv
// Single-port SRAM arbiter/sequencer sharing the memory port between fetch and
// LSU. Define LOBSTER_DBUS_RR_EN for round-robin instead of fixed LSU priority.
module lobster_dbus_arbiter
  import lobster_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DBUS_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                   clk,
  input logic                   rst,
  lobster_dbus_arbiter_if.master bus
);

  localparam int unsigned DW = DBUS_DATA_WIDTH;

  dbus_state_t           state;
  dbus_owner_t           owner_q;
  dbus_owner_t           grant_c;
  logic                  busy_q;
  logic                  mem_ce_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DW-1:0]         mem_wdata_q;
  logic                  if_done_q, if_err_q;
  logic                  ls_done_q, ls_err_q;
  logic [DW-1:0]         if_rdata_q, ls_rdata_q;
  logic                  expired;

`ifdef LOBSTER_DBUS_RR_EN
  dbus_owner_t rr_ptr;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_c = OWN_FETCH;
    if (bus.ls_req && bus.if_req) grant_c = rr_ptr;
    else if (bus.ls_req)          grant_c = OWN_LSU;
  end

  always_ff @(posedge clk) begin
    if (rst)                 rr_ptr <= OWN_LSU;
    else if (state == RESP)  rr_ptr <= dbus_other(owner_q);
  end
`else
  always_comb begin
    grant_c = OWN_FETCH;
    if (bus.ls_req) grant_c = OWN_LSU;
  end
`endif

  lobster_dbus_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == RESP),
    .run    (state == ACCESS),
    .expired(expired)
  );

  // Transaction sequencer: latch in IDLE, hold through ACCESS, pulse done in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_q     <= OWN_FETCH;
      busy_q      <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.ls_req) begin
            state    <= ACCESS;
            busy_q   <= 1'b1;
            mem_ce_q <= 1'b1;
            owner_q  <= grant_c;
            if (grant_c == OWN_LSU) begin
              mem_we_q    <= bus.ls_we;
              mem_addr_q  <= bus.ls_addr;
              mem_wdata_q <= bus.ls_wdata;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.if_addr;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_rdy || expired) begin
            state    <= RESP;
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_q == OWN_LSU) begin
              ls_done_q <= 1'b1;
              ls_err_q  <= ~bus.mem_rdy;
              if (bus.mem_rdy && !mem_we_q) ls_rdata_q <= bus.mem_rdata;
            end else begin
              if_done_q <= 1'b1;
              if_err_q  <= ~bus.mem_rdy;
              if (bus.mem_rdy) if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          if_done_q <= 1'b0;
          if_err_q  <= 1'b0;
          ls_done_q <= 1'b0;
          ls_err_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_err    = ls_err_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule

// File: doc/lobster_dbus_arbiter.md
# lobster_dbus_arbiter

Single-port SRAM bus arbiter and sequencer for the lobster128 core. It shares the one external memory port (ce/we/addr/data/rdy) between two requesters: the instruction-fetch stage and the load/store unit. Each access runs as a complete transaction with a rdy watchdog that turns a hung access into an error response. It sits between the CPU pipeline and the SRAM pins, replacing direct pipeline drive of ce/we/addr.

## Interface
- ADDR_WIDTH, 36: memory address width.
- TIMEOUT_CYCLES, 256: maximum cycles in ACCESS without mem_rdy before the access aborts; legal range ≥ 2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_done  out  1  one-cycle completion pulse to fetch.
- if_err  out  1  valid with if_done; access timed out.
- if_rdata  out  64  fetched word; valid with if_done.
- ls_req  in  1  load/store request; held until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  load/store address.
- ls_wdata  in  64  store data.
- ls_done, ls_err  out  1  as for fetch.
- ls_rdata  out  64  load data; valid with ls_done.
- mem_ce  out  1  SRAM command enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  64  SRAM write data.
- mem_rdata  in  64  SRAM read data; valid when mem_rdy=1.
- mem_rdy  in  1  SRAM access complete.
- busy  out  1  state ≠ IDLE.
- owner  out  1  current or last grant: 0 = fetch, 1 = LSU.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick an owner and latch addr, we (fetch forces we=0), and wdata into internal registers. Assert mem_ce, drive mem_we, and go to ACCESS. With no req, stay in IDLE.
- Default arbitration is fixed priority: LSU wins over fetch.
- ACCESS: mem_ce, mem_we, mem_addr and mem_wdata are held stable. The watchdog counter increments each cycle.
  - mem_rdy=1: capture mem_rdata into the owner's rdata register, drop mem_ce and mem_we, go to RESP with err=0.
  - Counter reaches TIMEOUT_CYCLES−1 with mem_rdy=0: drop mem_ce and mem_we, go to RESP with err=1. rdata keeps its previous value.
  - If mem_rdy=1 on the final counted cycle, mem_rdy wins and no error is raised.
- RESP: pulse the owner's done for exactly one cycle, with err if the access timed out. Clear the counter and return to IDLE. Requests are ignored in this state.
- Stores also return done. ls_rdata is unchanged by a store.
- A requester that still has req high in the IDLE cycle after its done has issued a new request.
- The non-owner's req may rise or fall at any time without effect until the next IDLE.
- A requester that drops req before its done is a protocol violation. The arbiter still completes the latched transaction.

## Timing
- All outputs are registered.
- Reset values: mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=ls_done=0, if_err=ls_err=0, if_rdata=ls_rdata=0, busy=0, owner=0. State=IDLE, counter=0, round-robin pointer favours LSU.
- Reset mid-transaction aborts immediately: mem_ce drops the next cycle and no done is issued.
- Latency with zero-wait memory: req in cycle 0 → mem_ce in cycle 1 → mem_rdy sampled in cycle 1 → done in cycle 2.
- Total latency is 3 cycles plus wait cycles.
- Throughput is at most one transaction per 3 cycles.
- Timeout: mem_ce is high for exactly TIMEOUT_CYCLES cycles, then err/done follows in the next cycle.

## Configuration
- LOBSTER_DBUS_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer flips to the other requester after each completed transaction, including timeouts.
  - When both requesters are high in IDLE, the one the pointer favours wins.
  - When only one requester is high, it wins regardless of the pointer.
- LOBSTER_DBUS_RR_EN undefined: fixed LSU priority. The pointer logic is absent.

## Structure
- Shared package lobster_pkg:
  - ADDR_WIDTH default.
  - dbus_owner_t enum (OWN_FETCH, OWN_LSU).
  - dbus_state_t enum (IDLE, ACCESS, RESP).
- Sub-module lobster_dbus_wdog: the watchdog counter.
  - Parameter TIMEOUT_CYCLES.
  - Inputs clk, rst, clear, run.
  - Output expired.
  - Counter width $clog2(TIMEOUT_CYCLES).
- The arbiter instantiates one lobster_dbus_wdog.

## Test plan
- Fetch only, addr 0xF800, SRAM returns 0x1122334455667788 with 0 waits → mem_ce high in cycle 1 only; if_done in cycle 2 with if_rdata=0x1122334455667788 and if_err=0.
- if_req and ls_req rise together, store of 0xDEAD to 0x100 (RR undefined) → LSU served first with mem_we=1 and mem_wdata=0xDEAD; fetch starts 3 cycles later.
- With LOBSTER_DBUS_RR_EN, both requesters held high for 4 transactions → grant order LSU, fetch, LSU, fetch.
- SRAM never asserts mem_rdy, TIMEOUT_CYCLES=4 → mem_ce high for 4 cycles; ls_done=ls_err=1 the next cycle; ls_rdata unchanged.
- 3 wait states, then mem_rdy → mem_addr stable throughout; done 5 cycles after req.
- rst asserted in the 2nd ACCESS cycle → mem_ce=0 the next cycle; no done pulse; busy=0; a new fetch afterwards completes normally.
